// File: rtl/pong_frame_renderer.sv
`default_nettype none
// ============================================================================
// Module   : pong_frame_renderer
// Brief    : 640x480@60 VGA raster generator drawing a ball and two paddles
//            from positions shadowed once per frame. Define CENTER_NET_EN to
//            add a dashed centre net.
// Revision : 1.0  initial release
// ============================================================================
module pong_frame_renderer #(
    parameter int          PIX_DIV    = 2,
    parameter int          BALL_SIZE  = 5,
    parameter int          PADDLE_W   = 10,
    parameter int          PADDLE_H   = 120,
    parameter logic [11:0] BG_COLOR   = 12'h000,
    parameter logic [11:0] BALL_COLOR = 12'hFFF,
    parameter logic [11:0] P1_COLOR   = 12'h0F0,
    parameter logic [11:0] P2_COLOR   = 12'hF00,
    parameter int          H_ACTIVE   = 640,
    parameter int          H_FP       = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BP       = 48,
    parameter int          V_ACTIVE   = 480,
    parameter int          V_FP       = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BP       = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  ball_x,
    input  logic [9:0]  ball_y,
    input  logic [9:0]  P1_x,
    input  logic [9:0]  P1_y,
    input  logic [9:0]  P2_x,
    input  logic [9:0]  P2_y,
    output logic [9:0]  X_pix,
    output logic [9:0]  Y_pix,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [11:0] rgb,
    output logic        frame_tick
);

    localparam int          H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int          V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int          DIV_W        = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [9:0]  C_H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  C_V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  C_H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0]  C_V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0]  C_V_ACT_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  C_HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  C_HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  C_VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  C_VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] C_BALL_SZ    = 11'(BALL_SIZE);
    localparam logic [10:0] C_PAD_W      = 11'(PADDLE_W);
    localparam logic [10:0] C_PAD_H      = 11'(PADDLE_H);

    logic w_pe;

    generate
        if (PIX_DIV <= 1) begin : g_pe_always
            assign w_pe = 1'b1;
        end else begin : g_pe_div
            localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(PIX_DIV - 1);
            logic [DIV_W-1:0] r_div;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_div <= '0;
                end else if (r_div == C_DIV_LAST) begin
                    r_div <= '0;
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end

            assign w_pe = (r_div == C_DIV_LAST);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Scan counters
    // ------------------------------------------------------------------
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       w_x_last;
    logic       w_y_last;
    logic       w_frame_latch;

    assign w_x_last      = (r_x == C_H_LAST);
    assign w_y_last      = (r_y == C_V_LAST);
    assign w_frame_latch = w_pe && w_x_last && (r_y == C_V_ACT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_pe) begin
            if (w_x_last) begin
                r_x <= '0;
                r_y <= w_y_last ? 10'd0 : r_y + 10'd1;
            end else begin
                r_x <= r_x + 10'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Position shadows, refreshed only at the top of vertical blanking
    // ------------------------------------------------------------------
    logic [9:0] r_ball_x, r_ball_y;
    logic [9:0] r_p1_x, r_p1_y;
    logic [9:0] r_p2_x, r_p2_y;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ball_x <= 10'd318;
            r_ball_y <= 10'd238;
            r_p1_x   <= 10'd20;
            r_p1_y   <= 10'd220;
            r_p2_x   <= 10'd618;
            r_p2_y   <= 10'd220;
        end else if (w_frame_latch) begin
            r_ball_x <= ball_x;
            r_ball_y <= ball_y;
            r_p1_x   <= P1_x;
            r_p1_y   <= P1_y;
            r_p2_x   <= P2_x;
            r_p2_y   <= P2_y;
        end
    end

    // ------------------------------------------------------------------
    // Hit tests: widened to 11 bits so objects near 1023 cannot wrap onto
    // the left or top edge of the screen.
    // ------------------------------------------------------------------
    logic [10:0] w_x11;
    logic [10:0] w_y11;
    logic        w_ball_hit;
    logic        w_p1_hit;
    logic        w_p2_hit;
    logic        w_net_hit;
    logic        w_active;

    assign w_x11 = {1'b0, r_x};
    assign w_y11 = {1'b0, r_y};

    assign w_ball_hit = (w_x11 >= {1'b0, r_ball_x}) && (w_x11 < ({1'b0, r_ball_x} + C_BALL_SZ)) &&
                        (w_y11 >= {1'b0, r_ball_y}) && (w_y11 < ({1'b0, r_ball_y} + C_BALL_SZ));
    assign w_p1_hit   = (w_x11 >= {1'b0, r_p1_x}) && (w_x11 < ({1'b0, r_p1_x} + C_PAD_W)) &&
                        (w_y11 >= {1'b0, r_p1_y}) && (w_y11 < ({1'b0, r_p1_y} + C_PAD_H));
    assign w_p2_hit   = (w_x11 >= {1'b0, r_p2_x}) && (w_x11 < ({1'b0, r_p2_x} + C_PAD_W)) &&
                        (w_y11 >= {1'b0, r_p2_y}) && (w_y11 < ({1'b0, r_p2_y} + C_PAD_H));

    assign w_active = (r_x < C_H_ACT) && (r_y < C_V_ACT);

`ifdef CENTER_NET_EN
    localparam logic [9:0]  C_NET_L     = 10'(H_ACTIVE / 2 - 2);
    localparam logic [9:0]  C_NET_R     = 10'(H_ACTIVE / 2 + 1);
    localparam logic [11:0] C_NET_COLOR = 12'hAAA;

    // 16 lines on, 16 lines off
    assign w_net_hit = (r_x >= C_NET_L) && (r_x <= C_NET_R) && !r_y[4];
`else
    localparam logic [11:0] C_NET_COLOR = BG_COLOR;

    assign w_net_hit = 1'b0;
`endif

    logic [11:0] w_rgb_next;
    logic        w_hsync_next;
    logic        w_vsync_next;

    always_comb begin
        w_rgb_next = BG_COLOR;
        if (!w_active) begin
            w_rgb_next = 12'h000;
        end else if (w_ball_hit) begin
            w_rgb_next = BALL_COLOR;
        end else if (w_p1_hit) begin
            w_rgb_next = P1_COLOR;
        end else if (w_p2_hit) begin
            w_rgb_next = P2_COLOR;
        end else if (w_net_hit) begin
            w_rgb_next = C_NET_COLOR;
        end
    end

    assign w_hsync_next = !((r_x >= C_HS_START) && (r_x < C_HS_END));
    assign w_vsync_next = !((r_y >= C_VS_START) && (r_y < C_VS_END));

    // ------------------------------------------------------------------
    // Output registers: one pixel period behind X_pix/Y_pix
    // ------------------------------------------------------------------
    logic        r_hsync;
    logic        r_vsync;
    logic        r_video_on;
    logic [11:0] r_rgb;
    logic        r_frame_tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hsync    <= 1'b1;
            r_vsync    <= 1'b1;
            r_video_on <= 1'b0;
            r_rgb      <= 12'h000;
        end else if (w_pe) begin
            r_hsync    <= w_hsync_next;
            r_vsync    <= w_vsync_next;
            r_video_on <= w_active;
            r_rgb      <= w_rgb_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_frame_latch;
        end
    end

    assign X_pix      = r_x;
    assign Y_pix      = r_y;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign video_on   = r_video_on;
    assign rgb        = r_rgb;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_pong_frame_renderer.sv
`default_nettype none
// Self-checking bench for pong_frame_renderer on a reduced raster geometry
// so several whole frames fit in a short run.
module tb_pong_frame_renderer;

    localparam int PD = 2;
    localparam int BS = 5;
    localparam int PW = 4;
    localparam int PH = 10;
    localparam int HA = 48, HF = 4, HS = 6, HB = 6;
    localparam int VA = 24, VF = 2, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam logic [11:0] BG_C   = 12'h000;
    localparam logic [11:0] BALL_C = 12'hFFF;
    localparam logic [11:0] P1_C   = 12'h0F0;
    localparam logic [11:0] P2_C   = 12'hF00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  ball_x = 10'd318, ball_y = 10'd238;
    logic [9:0]  p1_x = 10'd20, p1_y = 10'd220;
    logic [9:0]  p2_x = 10'd618, p2_y = 10'd220;
    logic [9:0]  X_pix, Y_pix;
    logic        hsync, vsync, video_on, frame_tick;
    logic [11:0] rgb;
    logic [35:0] w_obs;

    int n_cmp = 0;
    int n_err = 0;

    pong_frame_renderer #(
        .PIX_DIV(PD), .BALL_SIZE(BS), .PADDLE_W(PW), .PADDLE_H(PH),
        .BG_COLOR(BG_C), .BALL_COLOR(BALL_C), .P1_COLOR(P1_C), .P2_COLOR(P2_C),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .reset(rst),
        .ball_x(ball_x), .ball_y(ball_y),
        .P1_x(p1_x), .P1_y(p1_y), .P2_x(p2_x), .P2_y(p2_y),
        .X_pix(X_pix), .Y_pix(Y_pix), .hsync(hsync), .vsync(vsync),
        .video_on(video_on), .rgb(rgb), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    assign w_obs = {X_pix, Y_pix, hsync, vsync, video_on, rgb, frame_tick};

    // ------------------------------------------------------------------
    // Reference model: own counters and shadows; pushes the expected
    // registered outputs {hsync,vsync,video_on,rgb} on every pixel step.
    // ------------------------------------------------------------------
    int   m_div, m_x, m_y;
    logic m_pe_d, m_tick;
    int   sh_bx, sh_by, sh_p1x, sh_p1y, sh_p2x, sh_p2y;
    logic [14:0] exp_q[$];

    function automatic logic [14:0] exp_out(int x, int y);
        logic        hs, vs, von;
        logic [11:0] c;
        hs  = !(x >= HA + HF && x < HA + HF + HS);
        vs  = !(y >= VA + VF && y < VA + VF + VS);
        von = (x < HA) && (y < VA);
        c   = BG_C;
        if (!von) c = 12'h000;
        else if (x >= sh_bx && x < sh_bx + BS && y >= sh_by && y < sh_by + BS) c = BALL_C;
        else if (x >= sh_p1x && x < sh_p1x + PW && y >= sh_p1y && y < sh_p1y + PH) c = P1_C;
        else if (x >= sh_p2x && x < sh_p2x + PW && y >= sh_p2y && y < sh_p2y + PH) c = P2_C;
`ifdef CENTER_NET_EN
        else if (x >= HA / 2 - 2 && x <= HA / 2 + 1 && ((y / 16) % 2) == 0) c = 12'hAAA;
`endif
        return {hs, vs, von, c};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_div <= 0; m_x <= 0; m_y <= 0; m_pe_d <= 1'b0; m_tick <= 1'b0;
            sh_bx <= 318; sh_by <= 238; sh_p1x <= 20; sh_p1y <= 220; sh_p2x <= 618; sh_p2y <= 220;
            exp_q.delete();
        end else begin
            m_pe_d <= (m_div == PD - 1);
            m_tick <= (m_div == PD - 1) && (m_x == HT - 1) && (m_y == VA - 1);
            if (m_div == PD - 1) begin
                m_div <= 0;
                exp_q.delete();
                exp_q.push_back(exp_out(m_x, m_y));
                if (m_x == HT - 1 && m_y == VA - 1) begin
                    sh_bx  <= int'(ball_x); sh_by  <= int'(ball_y);
                    sh_p1x <= int'(p1_x);   sh_p1y <= int'(p1_y);
                    sh_p2x <= int'(p2_x);   sh_p2y <= int'(p2_y);
                end
                if (m_x == HT - 1) begin
                    m_x <= 0;
                    m_y <= (m_y == VT - 1) ? 0 : m_y + 1;
                end else begin
                    m_x <= m_x + 1;
                end
            end else begin
                m_div <= m_div + 1;
            end
        end
    end

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (w_obs !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0}) begin
            n_err++; $display("FAIL reset_values: got %h want %h", w_obs, {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0});
        end
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            n_cmp++;
            if (X_pix !== 10'(k / 2)) begin
                n_err++; $display("FAIL x_step clk%0d: got %0d want %0d", k, X_pix, k / 2);
            end
        end
    endtask

    task automatic test_raster();
        int cyc = 0, ticks = 0, t1 = 0, frame_p = -1, line_t = -1, line_p = -1;
        int vs_low = 0, first_hs = -1, wraps = 0;
        logic [9:0]  px = X_pix, py = Y_pix;
        logic [14:0] e;
        while (ticks < 2 && cyc < 3 * HT * VT * PD) begin
            @(negedge clk); cyc++;
            n_cmp++;
            if ({X_pix, Y_pix} !== {10'(m_x), 10'(m_y)}) begin
                n_err++; $display("FAIL raster_counters: got (%0d,%0d) want (%0d,%0d)", X_pix, Y_pix, m_x, m_y);
            end
            n_cmp++;
            if (frame_tick !== m_tick) begin
                n_err++; $display("FAIL raster_tick: got %b want %b at (%0d,%0d)", frame_tick, m_tick, m_x, m_y);
            end
            if (m_pe_d && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({hsync, vsync, video_on, rgb} !== e) begin
                    n_err++; $display("FAIL raster_pixel: got %h want %h at (%0d,%0d)", {hsync, vsync, video_on, rgb}, e, m_x, m_y);
                end
            end
            if (first_hs < 0 && hsync === 1'b0) first_hs = int'(X_pix);
            if (X_pix == 10'd0 && px == 10'(HT - 1)) begin
                if (line_t >= 0 && line_p < 0) line_p = cyc - line_t;
                line_t = cyc;
                n_cmp++;
                if (Y_pix !== ((py == 10'(VT - 1)) ? 10'd0 : py + 10'd1)) begin
                    n_err++; $display("FAIL line_wrap_y: got %0d after %0d", Y_pix, py);
                end
                if (py == 10'(VT - 1)) wraps++;
            end
            if (ticks == 1 && vsync === 1'b0) vs_low++;
            if (frame_tick === 1'b1) begin
                ticks++;
                if (ticks == 1) t1 = cyc;
                else frame_p = cyc - t1;
            end
            px = X_pix; py = Y_pix;
        end
        n_cmp++;
        if (ticks != 2) begin n_err++; $display("FAIL raster_timeout: got %0d ticks want 2", ticks); end
        n_cmp++;
        if (first_hs != HA + HF + 1) begin n_err++; $display("FAIL first_hsync_x: got %0d want %0d", first_hs, HA + HF + 1); end
        n_cmp++;
        if (line_p != HT * PD) begin n_err++; $display("FAIL line_period: got %0d want %0d", line_p, HT * PD); end
        n_cmp++;
        if (frame_p != HT * VT * PD) begin n_err++; $display("FAIL frame_period: got %0d want %0d", frame_p, HT * VT * PD); end
        n_cmp++;
        if (vs_low != VS * HT * PD) begin n_err++; $display("FAIL vsync_low_clks: got %0d want %0d", vs_low, VS * HT * PD); end
        n_cmp++;
        if (wraps != 1) begin n_err++; $display("FAIL frame_wraps: got %0d want 1", wraps); end
    endtask

    // New positions are presented mid-frame; the current frame must be
    // unchanged and the following frame must show exactly the new sprites.
    task automatic test_render(input string nm, input int bx, input int by, input int ax, input int ay,
                               input int cx, input int cy, input int eb, input int e1, input int e2);
        int cyc = 0, phase = 0, cb = 0, c1 = 0, c2 = 0;
        logic [14:0] e;
        while (phase < 3 && cyc < 3 * HT * VT * PD) begin
            @(negedge clk); cyc++;
            n_cmp++;
            if ({X_pix, Y_pix} !== {10'(m_x), 10'(m_y)}) begin
                n_err++; $display("FAIL %s_counters: got (%0d,%0d) want (%0d,%0d)", nm, X_pix, Y_pix, m_x, m_y);
            end
            if (m_pe_d && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({hsync, vsync, video_on, rgb} !== e) begin
                    n_err++; $display("FAIL %s_pixel: got %h want %h at (%0d,%0d)", nm, {hsync, vsync, video_on, rgb}, e, m_x, m_y);
                end
            end
            if (phase == 0 && m_y == 5) begin
                ball_x = 10'(bx); ball_y = 10'(by);
                p1_x = 10'(ax); p1_y = 10'(ay);
                p2_x = 10'(cx); p2_y = 10'(cy);
                phase = 1;
            end else if (phase >= 1 && frame_tick === 1'b1) begin
                if (phase == 1) begin
                    n_cmp++;
                    if ({X_pix, Y_pix} !== {10'd0, 10'(VA)}) begin
                        n_err++; $display("FAIL %s_tick_pos: got (%0d,%0d) want (0,%0d)", nm, X_pix, Y_pix, VA);
                    end
                end
                phase++;
            end else if (phase == 2 && m_pe_d) begin
                if (rgb === BALL_C) cb++;
                if (rgb === P1_C) c1++;
                if (rgb === P2_C) c2++;
            end
        end
        n_cmp++;
        if (phase != 3) begin n_err++; $display("FAIL %s_timeout: got phase %0d want 3", nm, phase); end
        n_cmp++;
        if (cb != eb) begin n_err++; $display("FAIL %s_ball_px: got %0d want %0d", nm, cb, eb); end
        n_cmp++;
        if (c1 != e1) begin n_err++; $display("FAIL %s_p1_px: got %0d want %0d", nm, c1, e1); end
        n_cmp++;
        if (c2 != e2) begin n_err++; $display("FAIL %s_p2_px: got %0d want %0d", nm, c2, e2); end
    endtask

    task automatic test_reset_midframe();
        int cyc = 0, spr = 0;
        bit seen = 0, done = 0;
        logic [14:0] e;
        ball_x = 10'd10; ball_y = 10'd8; p1_x = 10'd2; p1_y = 10'd4; p2_x = 10'd40; p2_y = 10'd4;
        while (!done && cyc < 3 * HT * VT * PD) begin
            @(negedge clk); cyc++;
            if (frame_tick === 1'b1) seen = 1;
            if (seen && m_x == 30 && m_y == 20) done = 1;
        end
        n_cmp++;
        if (!done) begin n_err++; $display("FAIL rstmid_reach: got cyc %0d, point (30,20) not reached", cyc); end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (w_obs !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0}) begin
            n_err++; $display("FAIL rstmid_async: got %h want %h", w_obs, {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0; done = 0;
        while (!done && cyc < 2 * HT * VT * PD) begin
            @(negedge clk); cyc++;
            if (m_pe_d && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({hsync, vsync, video_on, rgb} !== e) begin
                    n_err++; $display("FAIL rstmid_pixel: got %h want %h at (%0d,%0d)", {hsync, vsync, video_on, rgb}, e, m_x, m_y);
                end
                if (rgb === BALL_C || rgb === P1_C || rgb === P2_C) spr++;
            end
            if (frame_tick === 1'b1) done = 1;
        end
        n_cmp++;
        if (!done) begin n_err++; $display("FAIL rstmid_timeout: got no frame_tick within %0d clks", cyc); end
        n_cmp++;
        if (spr != 0) begin n_err++; $display("FAIL rstmid_default_frame: got %0d sprite px want 0", spr); end
    endtask

    initial begin
        test_reset();
        test_raster();
        test_render("shadow", 10, 8, 1023, 1023, 1023, 1023, 25, 0, 0);
        test_render("priority", 2, 8, 2, 4, 40, 4, 25, 20, 40);
        test_render("edge", 1020, 22, 46, 20, 1022, 1020, 0, 8, 0);
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pong_frame_renderer.md
Name: pong_frame_renderer

Overview:
- Display-side consumer of the game-state positions: takes ball and paddle coordinates and produces the 640x480@60 VGA raster.
- Generates the X_pix/Y_pix scan coordinates fed back to the ball-motion logic, plus hsync, vsync and 12-bit RGB.
- Shadows all object positions once per frame, at the start of vertical blanking, so objects never tear mid-frame.
- Sits between the game logic and the board's VGA DAC pins.

Parameters:
- PIX_DIV, 2, system clocks per pixel; pixel enable asserted once every PIX_DIV clocks (50 MHz -> 25 MHz).
- BALL_SIZE, 5, ball width and height in pixels.
- PADDLE_W, 10, paddle width in pixels.
- PADDLE_H, 120, paddle height in pixels.
- BG_COLOR, 12'h000, background RGB444.
- BALL_COLOR, 12'hFFF, ball RGB444.
- P1_COLOR, 12'h0F0, player-1 paddle RGB444.
- P2_COLOR, 12'hF00, player-2 paddle RGB444.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ball_x  in  10  ball left edge, pixels
- ball_y  in  10  ball top edge, pixels
- P1_x  in  10  player-1 paddle left edge
- P1_y  in  10  player-1 paddle top edge
- P2_x  in  10  player-2 paddle left edge
- P2_y  in  10  player-2 paddle top edge
- X_pix  out  10  current horizontal counter, 0..799
- Y_pix  out  10  current vertical counter, 0..524
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- video_on  out  1  high when the registered RGB pixel is in the active area
- rgb  out  12  pixel colour {R[3:0],G[3:0],B[3:0]}
- frame_tick  out  1  one-clk pulse at the start of vertical blanking

Behaviour:
- Reset is asynchronous and active-high; it is the only reset.
- Reset values:
  - divider = 0, X_pix = 0, Y_pix = 0.
  - hsync = 1, vsync = 1, video_on = 0, rgb = 0, frame_tick = 0.
  - Shadow registers: ball = (318, 238), P1 = (20, 220), P2 = (618, 220).
- Pixel enable (pe):
  - Divider counts 0..PIX_DIV-1; pe is high in the clk where divider == PIX_DIV-1.
  - PIX_DIV = 1 means pe is permanently high.
- Horizontal counter X_pix advances on pe.
  - Line total is 800: 640 active, 16 front porch, 96 sync, 48 back porch.
  - Wraps 799 -> 0, and Y_pix increments on that same pe.
- Vertical counter Y_pix:
  - Frame total is 525: 480 active, 10 front porch, 2 sync, 33 back porch.
  - Wraps 524 -> 0 together with X_pix 799 -> 0.
- Sync timing:
  - hsync low for X_pix in 656..751.
  - vsync low for Y_pix in 490..491.
- Output latency:
  - hsync, vsync, video_on and rgb are registered on pe.
  - They lag the X_pix/Y_pix they were computed from by exactly one pixel period.
- Shadow latch:
  - On the pe where the counters step from (799, 479) to (0, 480), capture all six position inputs into the shadow registers.
  - frame_tick pulses high for that single clk.
  - Inputs are sampled only there; changes at any other time have no effect until the next frame.
- Hit tests:
  - All hit tests use 11-bit sums, so an object near 1023 does not wrap.
  - Ball hit: sx <= X < sx+BALL_SIZE and sy <= Y < sy+BALL_SIZE.
  - Paddle hit: px <= X < px+PADDLE_W and py <= Y < py+PADDLE_H.
  - Objects partly off-screen are clipped by the active window; no error is raised.
- Colour priority: ball > P1 > P2 > net (optional feature) > background.
- Blanking: outside the active area (X >= 640 or Y >= 480), rgb = 0 and video_on = 0 regardless of hits.
- Reset mid-frame:
  - Counters and outputs return to their reset values immediately.
  - Shadow registers return to their defaults.
  - The first frame after reset renders the defaults.

Optional Feature:
- Macro: CENTER_NET_EN.
- Defined: a dashed centre net is drawn in colour 12'hAAA.
  - Covers X_pix 318..321 where Y_pix[4] == 0 (16 px on, 16 px off).
  - Priority is below both paddles and the ball.
- Not defined: no net logic is synthesised; the net region shows BG_COLOR.

Test Plan:
- Reset released, PIX_DIV = 2 -> X_pix steps every 2 clks; first hsync low when X_pix = 657 (registered copy of 656); line period 1600 clks; frame period 840000 clks.
- Counter wrap -> at X 799 -> 0, Y_pix increments; at (799, 524), both counters go to 0; vsync low for exactly 2 lines (3200 clks).
- Ball at (100, 50) presented mid-frame -> no change in the current frame; frame_tick pulses at (0, 480); next frame rgb = 12'hFFF exactly for X 100..104, Y 50..54.
- Ball at (20, 230) overlapping P1 at (20, 220) -> rgb = BALL_COLOR on the overlap, P1_COLOR elsewhere on the paddle; P2 at (618, 220) gives 12'hF00 for X 618..627, Y 220..339.
- Ball at (1020, 478) -> no wrap artefact at X 0..3; rows 478..479 are not drawn on the left edge; rgb = 0 in blanking.
- Assert reset at (300, 200) -> all outputs go to reset values in the same cycle without waiting for clk; after release, the ball renders at (318, 238); with CENTER_NET_EN, X = 320, Y = 5 -> 12'hAAA and Y = 20 -> BG_COLOR.
